scan_select_gen: RTL and testbench

//   Generates the rotating active-low 7-bit line select for the downstream 7:1 output mux.

---
 rtl/scan_pkg.sv | 12 +
 rtl/scan_tick_counter.sv | 23 ++
 rtl/scan_select_gen.sv | 115 +++++++++++
 tb/tb_scan_select_gen.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/scan_pkg.sv
// Shared types and helpers for the rotating line-select scanner.
package scan_pkg;
  localparam int N_LINES = 7;
  localparam logic [N_LINES-1:0] SEL_NONE = 7'b1111111;

  typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_GAP} state_t;

  // Active-low one-hot select: line 0 drives the MSB low, line 6 the LSB.
  function automatic logic [N_LINES-1:0] sel_from_index(input logic [2:0] idx);
    return SEL_NONE & ~(7'b1000000 >> idx);
  endfunction
endpackage

// File: rtl/scan_tick_counter.sv
// Cycle counter with synchronous clear and a terminal-count flag; wraps to 0 on terminal count.
module scan_tick_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             inc,
  input  logic [CNT_W-1:0] last,
  output logic             tc
);
  logic [CNT_W-1:0] count_reg;

  assign tc = (count_reg == last);

  always_ff @(posedge clk) begin
    if (!reset_n || clr) begin
      count_reg <= '0;
    end else if (inc) begin
      count_reg <= tc ? '0 : count_reg + 1'b1;
    end
  end
endmodule

// File: rtl/scan_select_gen.sv
// Rotating active-low line select with optional all-ones gap between lines,
// plus slot and frame start pulses for the data producers.
module scan_select_gen
  import scan_pkg::*;
#(
  parameter int N_LINES_P = 7,
  parameter int PRESCALE  = 50000,
  parameter int GAP       = 2,
  parameter int CNT_W     = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       en,
  output logic [6:0] select,
  output logic [2:0] index,
  output logic       slot_tick,
  output logic       frame_tick
);
  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = (GAP > 0) ? CNT_W'(GAP - 1) : '0;

  state_t     state_reg, state_next;
  logic [2:0] index_reg, index_next;
  logic [6:0] select_reg, select_next;
  logic       slot_tick_reg, slot_tick_next;
  logic       frame_tick_reg, frame_tick_next;
  logic       cnt_clr, cnt_inc, cnt_tc;
  logic [CNT_W-1:0] cnt_last;
  logic [2:0] index_adv;

  assign index_adv = (index_reg == 3'd6) ? 3'd0 : index_reg + 3'd1;
  assign cnt_last  = (state_reg == ST_GAP) ? GAP_LAST : PRE_LAST;

  scan_tick_counter #(.CNT_W(CNT_W)) u_counter (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (cnt_clr),
    .inc     (cnt_inc),
    .last    (cnt_last),
    .tc      (cnt_tc)
  );

  always_comb begin
    state_next      = state_reg;
    index_next      = index_reg;
    slot_tick_next  = 1'b0;
    frame_tick_next = 1'b0;
    cnt_clr         = 1'b0;
    cnt_inc         = 1'b0;
    if (!en) begin
      state_next = ST_IDLE;
      index_next = 3'd0;
      cnt_clr    = 1'b1;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          state_next      = ST_ACTIVE;
          index_next      = 3'd0;
          slot_tick_next  = 1'b1;
          frame_tick_next = 1'b1;
          cnt_clr         = 1'b1;
        end
        ST_ACTIVE: begin
          cnt_inc = 1'b1;
          if (cnt_tc) begin
            if (GAP > 0) begin
              state_next = ST_GAP;
            end else begin
              index_next      = index_adv;
              slot_tick_next  = 1'b1;
              frame_tick_next = (index_adv == 3'd0);
            end
          end
        end
        ST_GAP: begin
          cnt_inc = 1'b1;
          if (cnt_tc) begin
            state_next      = ST_ACTIVE;
            index_next      = index_adv;
            slot_tick_next  = 1'b1;
            frame_tick_next = (index_adv == 3'd0);
          end
        end
        default: begin
          state_next = ST_IDLE;
          index_next = 3'd0;
          cnt_clr    = 1'b1;
        end
      endcase
    end
    // Select is derived from the next state so a line change never overlaps two lows.
    select_next = (state_next == ST_ACTIVE) ? sel_from_index(index_next) : SEL_NONE;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg      <= ST_IDLE;
      index_reg      <= 3'd0;
      select_reg     <= SEL_NONE;
      slot_tick_reg  <= 1'b0;
      frame_tick_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      index_reg      <= index_next;
      select_reg     <= select_next;
      slot_tick_reg  <= slot_tick_next;
      frame_tick_reg <= frame_tick_next;
    end
  end

  assign select     = select_reg;
  assign index      = index_reg;
  assign slot_tick  = slot_tick_reg;
  assign frame_tick = frame_tick_reg;
endmodule

// File: tb/tb_scan_select_gen.sv
// Bench for scan_select_gen: a gapped and a gapless instance share stimulus and are checked every cycle.
module tb_scan_select_gen;
  localparam int P  = 4;
  localparam int GA = 1;
  localparam int GB = 0;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       en = 1'b0;
  logic [6:0] sel_a, sel_b;
  logic [2:0] idx_a, idx_b;
  logic       st_a, ft_a, st_b, ft_b;

  int tests = 0;
  int fails = 0;
  bit chk_on = 1'b0;

  // Model state: whether scanning is running and cycles since the line-0 start.
  bit run_m = 1'b0;
  int t_m = 0;

  always #5 clk = ~clk;

  scan_select_gen #(.PRESCALE(P), .GAP(GA), .CNT_W(16)) dut_a (
    .clk(clk), .reset_n(reset_n), .en(en),
    .select(sel_a), .index(idx_a), .slot_tick(st_a), .frame_tick(ft_a)
  );

  scan_select_gen #(.PRESCALE(P), .GAP(GB), .CNT_W(16)) dut_b (
    .clk(clk), .reset_n(reset_n), .en(en),
    .select(sel_b), .index(idx_b), .slot_tick(st_b), .frame_tick(ft_b)
  );

  always @(posedge clk) begin
    if (!reset_n || !en) begin
      run_m <= 1'b0;
      t_m   <= 0;
    end else if (!run_m) begin
      run_m <= 1'b1;
      t_m   <= 0;
    end else begin
      t_m <= t_m + 1;
    end
  end

  // Expected {select, index, slot_tick, frame_tick} from position inside the frame.
  function automatic logic [11:0] expect_out(input int g, input bit r, input int tt);
    int slot, pos, line, off;
    logic [6:0] s;
    if (!r) return {7'b1111111, 3'd0, 1'b0, 1'b0};
    slot = P + g;
    pos  = tt % (7 * slot);
    line = pos / slot;
    off  = pos % slot;
    s = 7'b1111111;
    if (off < P) s[6 - line] = 1'b0;
    return {s, 3'(line), (off == 0), (pos == 0)};
  endfunction

  initial begin
    logic [11:0] ea, eb, ga, gb;
    logic prev_st_a, prev_ft_a, prev_st_b, prev_ft_b;
    prev_st_a = 0; prev_ft_a = 0; prev_st_b = 0; prev_ft_b = 0;
    forever begin
      @(negedge clk);
      if (chk_on) begin
        ea = expect_out(GA, run_m, t_m);
        eb = expect_out(GB, run_m, t_m);
        ga = {sel_a, idx_a, st_a, ft_a};
        gb = {sel_b, idx_b, st_b, ft_b};
        tests++;
        if (ga !== ea) begin
          fails++;
          $display("FAIL model_a t=%0t got sel=%b idx=%0d st=%b ft=%b want sel=%b idx=%0d st=%b ft=%b",
                   $time, ga[11:5], ga[4:2], ga[1], ga[0], ea[11:5], ea[4:2], ea[1], ea[0]);
        end
        tests++;
        if (gb !== eb) begin
          fails++;
          $display("FAIL model_b t=%0t got sel=%b idx=%0d st=%b ft=%b want sel=%b idx=%0d st=%b ft=%b",
                   $time, gb[11:5], gb[4:2], gb[1], gb[0], eb[11:5], eb[4:2], eb[1], eb[0]);
        end
        tests++;
        if ($countones(~sel_a) > 1 || $countones(~sel_b) > 1 || idx_a > 3'd6 || idx_b > 3'd6 ||
            (st_a && prev_st_a) || (ft_a && prev_ft_a) || (st_b && prev_st_b) || (ft_b && prev_ft_b)) begin
          fails++;
          $display("FAIL invariant t=%0t sel_a=%b sel_b=%b idx_a=%0d idx_b=%0d st_a=%b ft_a=%b st_b=%b ft_b=%b",
                   $time, sel_a, sel_b, idx_a, idx_b, st_a, ft_a, st_b, ft_b);
        end
        prev_st_a = st_a; prev_ft_a = ft_a; prev_st_b = st_b; prev_ft_b = ft_b;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string name, input logic [6:0] got, input logic [6:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%b want=%b", name, got, exp);
    end
    $display("[TB] %s got=%b want=%b", name, got, exp);
  endtask

  initial begin
    reset_n = 1'b0;
    en = 1'b1;
    tick();
    chk_on = 1'b1;
    repeat (2) tick();
    lit("reset_sel", sel_a, 7'b1111111);
    lit("reset_idx", {4'd0, idx_a}, 7'd0);
    lit("reset_ticks", {5'd0, st_a, ft_a}, 7'd0);

    reset_n = 1'b1;
    tick();
    for (int pos = 0; pos <= 52; pos++) begin
      case (pos)
        0:  begin lit("p0_sel", sel_a, 7'b0111111); lit("p0_ft", {6'd0, ft_a}, 7'd1); end
        4:  lit("p4_gap_sel", sel_a, 7'b1111111);
        5:  begin lit("p5_sel", sel_a, 7'b1011111); lit("p5_idx", {4'd0, idx_a}, 7'd1); end
        27: lit("b_p27_sel", sel_b, 7'b1111110);
        28: begin lit("b_p28_sel", sel_b, 7'b0111111); lit("b_p28_ft", {6'd0, ft_b}, 7'd1); end
        33: lit("p33_sel", sel_a, 7'b1111110);
        34: begin lit("p34_gap_sel", sel_a, 7'b1111111); lit("p34_idx", {4'd0, idx_a}, 7'd6); end
        35: begin lit("p35_sel", sel_a, 7'b0111111); lit("p35_ft", {6'd0, ft_a}, 7'd1); end
        52: begin lit("p52_sel", sel_a, 7'b1110111); lit("p52_idx", {4'd0, idx_a}, 7'd3); end
        default: ;
      endcase
      if (pos < 52) tick();
    end

    en = 1'b0;
    tick();
    lit("endrop_sel", sel_a, 7'b1111111);
    lit("endrop_idx", {4'd0, idx_a}, 7'd0);
    tick();
    en = 1'b1;
    tick();
    lit("reen_sel", sel_a, 7'b0111111);
    lit("reen_ft", {6'd0, ft_a}, 7'd1);

    repeat (29) tick();
    lit("gap5_sel", sel_a, 7'b1111111);
    lit("gap5_idx", {4'd0, idx_a}, 7'd5);
    reset_n = 1'b0;
    tick();
    lit("rstgap_sel", sel_a, 7'b1111111);
    lit("rstgap_idx", {4'd0, idx_a}, 7'd0);
    reset_n = 1'b1;
    tick();
    lit("rstrel_sel", sel_a, 7'b0111111);
    lit("rstrel_ft", {6'd0, ft_a}, 7'd1);

    repeat (3) tick();
    reset_n = 1'b0;
    en = 1'b0;
    tick();
    lit("both_low_sel", sel_a, 7'b1111111);
    reset_n = 1'b1;
    en = 1'b1;
    repeat (40) tick();

    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
